// File: rtl/sobel_edge_threshold_pkg.sv
// Shared types and constants for the Sobel edge-threshold slice.
// Holds the pixel type, the adaptive-sum width, the default reset threshold
// and two small pixel helpers (max and 8-bit saturation).
package sobel_pkg;

  localparam int PIX_W = 8;
  localparam int SUM_W = 24;

  typedef logic [PIX_W-1:0] pix_t;

  localparam pix_t DEF_RST_THR = 8'd64;

  // Larger of two pixel magnitudes.
  function automatic pix_t pix_max(input pix_t a, input pix_t b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  // Clamp a SUM_W+1 bit value into the 8-bit pixel range.
  function automatic pix_t sat_pix(input logic [SUM_W:0] v);
    if (v > {{(SUM_W + 1 - PIX_W){1'b0}}, 8'hFF}) begin
      return 8'hFF;
    end else begin
      return v[PIX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/sobel_edge_threshold_if.sv
// Stream/result bundle between the Sobel magnitude source and the
// edge-threshold block. The slave modport is the edge-threshold block; the
// master modport is whoever drives magnitudes and reads the edge map/stats.
interface sobel_edge_threshold_if
  import sobel_pkg::*;
#(
  parameter int CNT_W = 16
);

  pix_t             mag_in;
  logic             mag_valid;
  pix_t             thr_in;
  logic             edge_out;
  logic             edge_valid;
  logic             frame_done;
  logic [CNT_W-1:0] edge_count;
  pix_t             mag_max;
  pix_t             thr_cur;

  modport slave (
    input  mag_in,
    input  mag_valid,
    input  thr_in,
    output edge_out,
    output edge_valid,
    output frame_done,
    output edge_count,
    output mag_max,
    output thr_cur
  );

  modport master (
    output mag_in,
    output mag_valid,
    output thr_in,
    input  edge_out,
    input  edge_valid,
    input  frame_done,
    input  edge_count,
    input  mag_max,
    input  thr_cur
  );

endinterface

// File: rtl/sobel_edge_threshold_stats.sv
// edge_frame_stats: per-frame accumulators for the edge-threshold block.
// Counts edges, tracks the maximum magnitude and (when SOBEL_ADAPT_THR_EN is
// defined) sums magnitudes. On the accepted last pixel of a frame it latches
// the finished statistics, clears the accumulators and loads the threshold
// for the next frame. Without SOBEL_ADAPT_THR_EN the next threshold is simply
// thr_in and the magnitude sum is not built.
module edge_frame_stats
  import sobel_pkg::*;
#(
  parameter int   CNT_W   = 16,
  parameter pix_t RST_THR = DEF_RST_THR,
  parameter int   SHIFT   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             accept,
  input  logic             last,
  input  logic             is_edge,
  input  pix_t             mag,
  input  pix_t             thr_in,
  output logic [CNT_W-1:0] edge_count,
  output pix_t             mag_max,
  output pix_t             thr_cur
);

  logic [CNT_W-1:0] cnt_acc_r;
  pix_t             max_acc_r;
  logic [CNT_W-1:0] cnt_final_s;
  pix_t             max_final_s;
  pix_t             next_thr_s;
  logic [CNT_W-1:0] edge_count_r;
  pix_t             mag_max_r;
  pix_t             thr_cur_r;

`ifdef SOBEL_ADAPT_THR_EN
  logic [SUM_W-1:0] sum_acc_r;
  logic [SUM_W-1:0] sum_final_s;
  logic [SUM_W:0]   adapt_s;
`endif

  // Accumulator values including the pixel being accepted this cycle.
  always_comb begin
    cnt_final_s = cnt_acc_r + {{(CNT_W - 1){1'b0}}, is_edge};
    max_final_s = pix_max(max_acc_r, mag);
`ifdef SOBEL_ADAPT_THR_EN
    sum_final_s = sum_acc_r + {{(SUM_W - PIX_W){1'b0}}, mag};
    adapt_s     = {1'b0, (sum_final_s >> SHIFT)} + {{(SUM_W + 1 - PIX_W){1'b0}}, thr_in};
    next_thr_s  = sat_pix(adapt_s);
`else
    next_thr_s  = thr_in;
`endif
  end

  // Accumulate per beat; latch stats and the next threshold at the frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_acc_r    <= {CNT_W{1'b0}};
      max_acc_r    <= 8'd0;
      edge_count_r <= {CNT_W{1'b0}};
      mag_max_r    <= 8'd0;
      thr_cur_r    <= RST_THR;
    end else if (clr) begin
      cnt_acc_r <= {CNT_W{1'b0}};
      max_acc_r <= 8'd0;
      thr_cur_r <= RST_THR;
    end else if (accept) begin
      if (last) begin
        edge_count_r <= cnt_final_s;
        mag_max_r    <= max_final_s;
        cnt_acc_r    <= {CNT_W{1'b0}};
        max_acc_r    <= 8'd0;
        thr_cur_r    <= next_thr_s;
      end else begin
        cnt_acc_r <= cnt_final_s;
        max_acc_r <= max_final_s;
      end
    end
  end

`ifdef SOBEL_ADAPT_THR_EN
  // Frame magnitude sum feeding the adaptive threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_acc_r <= {SUM_W{1'b0}};
    end else if (clr) begin
      sum_acc_r <= {SUM_W{1'b0}};
    end else if (accept) begin
      if (last) begin
        sum_acc_r <= {SUM_W{1'b0}};
      end else begin
        sum_acc_r <= sum_final_s;
      end
    end
  end
`endif

  assign edge_count = edge_count_r;
  assign mag_max    = mag_max_r;
  assign thr_cur    = thr_cur_r;

endmodule

// File: rtl/sobel_edge_threshold.sv
// sobel_edge_threshold: binarises the Sobel magnitude stream into a 1-bit
// edge map and publishes per-frame edge count, maximum magnitude and the
// threshold in force. Frames are found by counting valid beats (OUT_W x OUT_H)
// because the upstream stage sends no frame markers. The block has a single
// streaming state; the frame boundary is simply the accepted last pixel.
// Optional feature macro: SOBEL_ADAPT_THR_EN (adaptive next-frame threshold).
module sobel_edge_threshold
  import sobel_pkg::*;
#(
  parameter int   IMG_W   = 256,
  parameter int   IMG_H   = 256,
  parameter pix_t RST_THR = DEF_RST_THR,
  parameter int   SHIFT   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  sobel_edge_threshold_if.slave bus
);

  localparam int OUT_W = IMG_W - 2;
  localparam int OUT_H = IMG_H - 2;
  localparam int CNT_W = $clog2(OUT_W * OUT_H + 1);
  localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  logic [COL_W-1:0] col_r;
  logic [ROW_W-1:0] row_r;
  logic             col_last_s;
  logic             row_last_s;
  logic             last_s;
  logic             edge_s;
  logic             edge_out_r;
  logic             edge_valid_r;
  logic             frame_done_r;
  logic [CNT_W-1:0] edge_count_s;
  pix_t             mag_max_s;
  pix_t             thr_cur_s;

  // Frame position decode and the strict edge compare.
  always_comb begin
    col_last_s = (col_r == COL_W'(OUT_W - 1));
    row_last_s = (row_r == ROW_W'(OUT_H - 1));
    last_s     = bus.mag_valid & col_last_s & row_last_s;
    edge_s     = (bus.mag_in > thr_cur_s);
  end

  // Column/row counters advance only on accepted beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r <= {COL_W{1'b0}};
      row_r <= {ROW_W{1'b0}};
    end else if (clr) begin
      col_r <= {COL_W{1'b0}};
      row_r <= {ROW_W{1'b0}};
    end else if (bus.mag_valid) begin
      if (col_last_s) begin
        col_r <= {COL_W{1'b0}};
        if (row_last_s) begin
          row_r <= {ROW_W{1'b0}};
        end else begin
          row_r <= row_r + ROW_W'(1);
        end
      end else begin
        col_r <= col_r + COL_W'(1);
      end
    end
  end

  // Registered edge map; edge_out holds its value between valid beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_out_r   <= 1'b0;
      edge_valid_r <= 1'b0;
      frame_done_r <= 1'b0;
    end else if (clr) begin
      edge_valid_r <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      edge_valid_r <= bus.mag_valid;
      frame_done_r <= last_s;
      if (bus.mag_valid) begin
        edge_out_r <= edge_s;
      end
    end
  end

  edge_frame_stats #(
    .CNT_W   (CNT_W),
    .RST_THR (RST_THR),
    .SHIFT   (SHIFT)
  ) u_stats (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .accept     (bus.mag_valid),
    .last       (last_s),
    .is_edge    (edge_s),
    .mag        (bus.mag_in),
    .thr_in     (bus.thr_in),
    .edge_count (edge_count_s),
    .mag_max    (mag_max_s),
    .thr_cur    (thr_cur_s)
  );

  assign bus.edge_out   = edge_out_r;
  assign bus.edge_valid = edge_valid_r;
  assign bus.frame_done = frame_done_r;
  assign bus.edge_count = edge_count_s;
  assign bus.mag_max    = mag_max_s;
  assign bus.thr_cur    = thr_cur_s;

endmodule

// File: tb/tb_sobel_edge_threshold.sv
// Directed bench for sobel_edge_threshold on a 6x6 image (16 pixels/frame).
// Covers reset, mid-frame reset, static compare, valid gaps, clr abort,
// back-to-back frames and, with SOBEL_ADAPT_THR_EN, the adaptive threshold.
module tb_sobel_edge_threshold;
  import sobel_pkg::*;

  localparam int IMG_W = 6;
  localparam int IMG_H = 6;
  localparam int SHIFT = 4;
  localparam int CNT_W = $clog2((IMG_W - 2) * (IMG_H - 2) + 1);

`ifdef SOBEL_ADAPT_THR_EN
  localparam int THR_A1    = 130; // 16*100 >> 4 + 30
  localparam int THR_ALT   = 94;  // (8*64 + 8*65) >> 4 + 30
  localparam int THR_B2B_A = 151; // (15*50 + 80) >> 4 + 100
  localparam int THR_B2B_B = 100; // 16*70 >> 4 + 30
`else
  localparam int THR_A1    = 30;
  localparam int THR_ALT   = 30;
  localparam int THR_B2B_A = 100;
  localparam int THR_B2B_B = 30;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  logic last_edge;
  int   vectors = 0;
  int   miscompares = 0;

  sobel_edge_threshold_if #(.CNT_W(CNT_W)) bus ();

  sobel_edge_threshold #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .RST_THR (8'd64),
    .SHIFT   (SHIFT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One accepted pixel; outputs checked one cycle later.
  task automatic beat(input string tag, input logic [7:0] m, input logic e, input logic fd);
    bus.mag_valid = 1'b1;
    bus.mag_in    = m;
    @(posedge clk); #1;
    chk({tag, " edge_valid"}, bus.edge_valid, 1);
    chk({tag, " edge_out"}, bus.edge_out, e);
    chk({tag, " frame_done"}, bus.frame_done, fd);
    last_edge = e;
  endtask

  // One idle cycle; nothing valid, edge_out held.
  task automatic idle(input string tag);
    bus.mag_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, " idle edge_valid"}, bus.edge_valid, 0);
    chk({tag, " idle frame_done"}, bus.frame_done, 0);
    chk({tag, " idle edge_out"}, bus.edge_out, last_edge);
  endtask

  task automatic do_clr(input string tag, input logic v, input logic [7:0] m);
    bus.mag_valid = v;
    bus.mag_in    = m;
    clr           = 1'b1;
    @(posedge clk); #1;
    clr           = 1'b0;
    bus.mag_valid = 1'b0;
    chk({tag, " clr edge_valid"}, bus.edge_valid, 0);
    chk({tag, " clr frame_done"}, bus.frame_done, 0);
    chk({tag, " clr thr_cur"}, bus.thr_cur, 64);
  endtask

  task automatic stats(input string tag, input int ec, input int mm, input int thr);
    chk({tag, " edge_count"}, bus.edge_count, ec);
    chk({tag, " mag_max"}, bus.mag_max, mm);
    chk({tag, " thr_cur"}, bus.thr_cur, thr);
  endtask

  // 16 pixels alternating 64/65 against threshold 64, optional random gaps.
  task automatic frame_alt(input string tag, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        int n;
        n = $urandom_range(0, 3);
        for (int g = 0; g < n; g++) idle(tag);
      end
      beat(tag, (i % 2 == 0) ? 8'd64 : 8'd65, (i % 2 == 1), (i == 15));
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    clr           = 1'b0;
    bus.mag_valid = 1'b0;
    bus.mag_in    = 8'd0;
    bus.thr_in    = 8'd0;
    last_edge     = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst edge_out", bus.edge_out, 0);
    chk("rst edge_valid", bus.edge_valid, 0);
    chk("rst frame_done", bus.frame_done, 0);
    stats("rst", 0, 0, 64);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-rst edge_valid", bus.edge_valid, 0);
    stats("post-rst", 0, 0, 64);

    // Mid-frame reset after 5 pixels discards the partial frame.
    bus.thr_in = 8'd30;
    for (int i = 0; i < 5; i++) beat("pre-rst", 8'd100, 1'b1, 1'b0);
    rst_n         = 1'b0;
    bus.mag_valid = 1'b0;
    #1;
    chk("async rst edge_valid", bus.edge_valid, 0);
    chk("async rst edge_out", bus.edge_out, 0);
    chk("async rst frame_done", bus.frame_done, 0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    last_edge = 1'b0;
    for (int i = 0; i < 16; i++) beat("after-rst", 8'd100, 1'b1, (i == 15));
    stats("after-rst", 16, 100, THR_A1);
    idle("after-rst");

    // Static compare, no gaps.
    do_clr("alt", 1'b0, 8'd0);
    stats("alt held", 16, 100, 64);
    frame_alt("alt", 1'b0);
    stats("alt", 8, 65, THR_ALT);
    idle("alt");

    // Same frame with random valid gaps.
    do_clr("gaps", 1'b0, 8'd0);
    frame_alt("gaps", 1'b1);
    stats("gaps", 8, 65, THR_ALT);
    idle("gaps");

    // clr after 7 pixels, coinciding with a valid beat.
    do_clr("abort", 1'b0, 8'd0);
    for (int i = 0; i < 7; i++) beat("abort", 8'd200, 1'b1, 1'b0);
    do_clr("abort", 1'b1, 8'd255);
    stats("abort held", 8, 65, 64);
    frame_alt("abort next", 1'b0);
    stats("abort next", 8, 65, THR_ALT);
    idle("abort next");

    // Back-to-back frames; last pixel judged with old threshold, next with new.
    do_clr("b2b", 1'b0, 8'd0);
    bus.thr_in = 8'd100;
    for (int i = 0; i < 15; i++) beat("b2b A", 8'd50, 1'b0, 1'b0);
    beat("b2b A last", 8'd80, 1'b1, 1'b1);
    stats("b2b A", 1, 80, THR_B2B_A);
    bus.thr_in = 8'd30;
    beat("b2b B first", 8'd70, 1'b0, 1'b0);
    stats("b2b B first", 1, 80, THR_B2B_A);
    for (int i = 1; i < 15; i++) beat("b2b B", 8'd70, 1'b0, 1'b0);
    stats("b2b B mid", 1, 80, THR_B2B_A);
    beat("b2b B last", 8'd70, 1'b0, 1'b1);
    stats("b2b B", 0, 70, THR_B2B_B);
    idle("b2b B");

`ifdef SOBEL_ADAPT_THR_EN
    // Adaptive threshold: 100s give 110, then 255s saturate at 255.
    do_clr("adapt", 1'b0, 8'd0);
    bus.thr_in = 8'd10;
    for (int i = 0; i < 16; i++) beat("adapt 100", 8'd100, 1'b1, (i == 15));
    stats("adapt 100", 16, 100, 110);
    for (int i = 0; i < 16; i++) beat("adapt 255", 8'd255, 1'b1, (i == 15));
    stats("adapt 255", 16, 255, 255);
    idle("adapt");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
